// File: rtl/sram_obi_arbiter.sv
// Round-robin merge of the cv32e40p OBI instruction and data ports onto one
// pipelined single-port SRAM, returning read data to the port that asked for it.
module sram_obi_arbiter #(
    parameter int unsigned AddrWidth = 11,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_rvalid_o,
    output logic [DataWidth-1:0] instr_rdata_o,

    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,

    output logic                 sram_req_o,
    output logic [3:0]           sram_wen_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    logic last_q;
    logic pend_q;
    logic port_q;

    logic gnt_instr;
    logic gnt_data;

    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (!rst_i) begin
            if (instr_req_i && data_req_i) begin
                if (last_q) begin
                    gnt_instr = 1'b1;
                end else begin
                    gnt_data = 1'b1;
                end
            end else if (instr_req_i) begin
                gnt_instr = 1'b1;
            end else if (data_req_i) begin
                gnt_data = 1'b1;
            end
        end
    end

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    always_comb begin
        sram_req_o   = gnt_instr | gnt_data;
        sram_wen_o   = 4'b0000;
        sram_addr_o  = instr_addr_i[AddrWidth+1:2];
        sram_wdata_o = data_wdata_i;
        if (gnt_data) begin
            sram_addr_o = data_addr_i[AddrWidth+1:2];
            if (data_we_i) begin
                sram_wen_o = data_be_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
            pend_q <= 1'b0;
            port_q <= 1'b0;
        end else if (gnt_instr || gnt_data) begin
            pend_q <= 1'b1;
            port_q <= gnt_data;
            last_q <= gnt_data;
        end else begin
            pend_q <= 1'b0;
        end
    end

    // A response still in flight when reset arrives is suppressed immediately.
    assign instr_rvalid_o = pend_q & ~port_q & ~rst_i;
    assign data_rvalid_o  = pend_q &  port_q & ~rst_i;
    assign instr_rdata_o  = sram_rdata_i;
    assign data_rdata_o   = sram_rdata_i;

    // Address bits outside the SRAM window are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:AddrWidth+2], instr_addr_i[1:0],
                                data_addr_i[31:AddrWidth+2], data_addr_i[1:0]};

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Directed bench for sram_obi_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_obi_arbiter;

    localparam int AW = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_req;
    logic [3:0]  sram_wen;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sram_obi_arbiter #(.AddrWidth(AW), .DataWidth(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .sram_req_o     (sram_req),
        .sram_wen_o     (sram_wen),
        .sram_addr_o    (sram_addr),
        .sram_wdata_o   (sram_wdata),
        .sram_rdata_i   (sram_rdata)
    );

    // SRAM returns the pre-write word, one cycle after the request
    always @(posedge clk) begin
        logic [31:0] word;
        if (sram_req) begin
            word = mem[sram_addr];
            sram_rdata <= word;
            for (int b = 0; b < 4; b++) begin
                if (sram_wen[b]) word[b*8 +: 8] = sram_wdata[b*8 +: 8];
            end
            mem[sram_addr] <= word;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        instr_req  = ireq;
        instr_addr = iaddr;
        data_req   = dreq;
        data_we    = dwe;
        data_be    = dbe;
        data_addr  = daddr;
        data_wdata = dwdata;
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_igntrst"},  {31'b0, instr_gnt},    32'h0);
        checkOutput({tag, "_dgntrst"},  {31'b0, data_gnt},     32'h0);
        checkOutput({tag, "_ivldrst"},  {31'b0, instr_rvalid}, 32'h0);
        checkOutput({tag, "_dvldrst"},  {31'b0, data_rvalid},  32'h0);
        checkOutput({tag, "_sreqrst"},  {31'b0, sram_req},     32'h0);
        checkOutput({tag, "_swenrst"},  {28'b0, sram_wen},     32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
        sram_rdata = 32'h0;

        // Reset with both requests high: no grants allowed
        rst = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        checkResetOutputs("reset");
        stepCycle();
        rst = 1'b0;
        idle();
        checkOutput("post_reset_ivld", {31'b0, instr_rvalid}, 32'h0);
        checkOutput("post_reset_dvld", {31'b0, data_rvalid},  32'h0);
        stepCycle();

        // Single instruction read
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("i_gnt",   {31'b0, instr_gnt}, 32'h1);
        checkOutput("i_dgnt",  {31'b0, data_gnt},  32'h0);
        checkOutput("i_sreq",  {31'b0, sram_req},  32'h1);
        checkOutput("i_saddr", {21'b0, sram_addr}, 32'h4);
        checkOutput("i_swen",  {28'b0, sram_wen},  32'h0);
        stepCycle();
        idle();
        checkOutput("i_rvalid", {31'b0, instr_rvalid}, 32'h1);
        checkOutput("i_rdata",  instr_rdata,           32'hDEAD_BEEF);
        checkOutput("i_dvld",   {31'b0, data_rvalid},  32'h0);
        stepCycle();
        checkOutput("i_rvalid_once", {31'b0, instr_rvalid}, 32'h0);

        // Byte write then read back
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00);
        checkOutput("w_gnt",   {31'b0, data_gnt},  32'h1);
        checkOutput("w_swen",  {28'b0, sram_wen},  32'h2);
        checkOutput("w_saddr", {21'b0, sram_addr}, 32'h8);
        checkOutput("w_wdata", sram_wdata,         32'h0000_AB00);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h20, 32'h0);
        checkOutput("w_rvalid", {31'b0, data_rvalid}, 32'h1);
        checkOutput("r_gnt",    {31'b0, data_gnt},    32'h1);
        checkOutput("r_swen",   {28'b0, sram_wen},    32'h0);
        stepCycle();
        idle();
        checkOutput("r_rvalid", {31'b0, data_rvalid}, 32'h1);
        checkOutput("r_rdata",  data_rdata,           32'h1000_AB08);
        stepCycle();

        // Contention after a fresh reset: data wins first, then alternate
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
            checkOutput($sformatf("c%0d_dgnt", k), {31'b0, data_gnt},  (k % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("c%0d_ignt", k), {31'b0, instr_gnt}, (k % 2 == 0) ? 32'h0 : 32'h1);
            if (k > 0) begin
                checkOutput($sformatf("c%0d_dvld", k), {31'b0, data_rvalid},  (k % 2 == 1) ? 32'h1 : 32'h0);
                checkOutput($sformatf("c%0d_ivld", k), {31'b0, instr_rvalid}, (k % 2 == 0) ? 32'h1 : 32'h0);
                checkOutput($sformatf("c%0d_rdata", k), (k % 2 == 1) ? data_rdata : instr_rdata,
                            (k % 2 == 1) ? 32'h1000_0001 : 32'hDEAD_BEEF);
            end
            stepCycle();
        end
        idle();
        checkOutput("c_last_ivld", {31'b0, instr_rvalid}, 32'h1);
        checkOutput("c_last_dvld", {31'b0, data_rvalid},  32'h0);
        checkOutput("c_last_data", instr_rdata,           32'hDEAD_BEEF);
        stepCycle();

        // Back-to-back data reads of words 0, 1, 2
        for (int k = 0; k < 4; k++) begin
            if (k < 3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'(k * 4), 32'h0);
            else       idle();
            if (k < 3) checkOutput($sformatf("b%0d_gnt", k), {31'b0, data_gnt}, 32'h1);
            checkOutput($sformatf("b%0d_dvld", k), {31'b0, data_rvalid}, (k == 0) ? 32'h0 : 32'h1);
            if (k > 0) checkOutput($sformatf("b%0d_rdata", k), data_rdata, 32'h1000_0000 + 32'(k - 1));
            stepCycle();
        end

        // Aliasing: 0x2004 maps onto word 1
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0);
        checkOutput("alias_saddr", {21'b0, sram_addr}, 32'h1);
        stepCycle();
        idle();
        checkOutput("alias_rdata", data_rdata, 32'h1000_0001);
        stepCycle();

        // Reset arriving while a data read is outstanding
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        checkOutput("rm_gnt", {31'b0, data_gnt}, 32'h1);
        stepCycle();
        rst = 1'b1;
        idle();
        checkResetOutputs("rm_n1");
        stepCycle();
        rst = 1'b0;
        checkOutput("rm_n2_dvld", {31'b0, data_rvalid}, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("rm_after_gnt", {31'b0, instr_gnt}, 32'h1);
        stepCycle();
        idle();
        checkOutput("rm_after_vld",   {31'b0, instr_rvalid}, 32'h1);
        checkOutput("rm_after_rdata", instr_rdata,           32'hDEAD_BEEF);
        stepCycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
